// File: rtl/conv_window3x3.sv
// 3x3 sliding-window generator: raster pixel stream in, one flattened 9-word
// window per beat out. Two line buffers feed the window's right column.
module conv_window3x3 #(
  parameter int NBITS = 20,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NBITS-1:0]   pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic [9*NBITS-1:0] win_out,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               win_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;
  // [r][c] packing places word 3*r+c at bits (3*r+c)*NBITS
  typedef logic [2:0][2:0][NBITS-1:0] win_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [NBITS-1:0] lb0_q [IMG_W];
  logic [NBITS-1:0] lb1_q [IMG_W];
  win_t             win_q, win_d, out_q;
  logic             vld_q, last_q;

  logic accept, consume, col_wrap, frame_end, complete;

  assign pix_ready = !reset && (state_q != DRAIN) && (!vld_q || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign consume   = vld_q && win_ready;
  assign col_wrap  = (col_q == COL_MAX);
  assign frame_end = col_wrap && (row_q == ROW_MAX);
  assign complete  = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  assign win_out   = out_q;
  assign win_valid = vld_q;
  assign win_last  = last_q;

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_q[col_q];
    win_d[1][2] = lb0_q[col_q];
    win_d[2][2] = pix_in;
  end

  // Data storage is never reset: rows 0..1 rewrite it before any window uses it.
  always_ff @(posedge clock) begin
    if (accept) begin
      win_q        <= win_d;
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    case (state_q)
      FILL:    if (accept && col_wrap && row_q == RW'(1)) state_d = RUN;
      RUN:     if (accept && frame_end) state_d = DRAIN;
      DRAIN:   if (consume && last_q) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      // a new window may replace the one being consumed on the same edge
      if (complete) begin
        out_q  <= win_d;
        vld_q  <= 1'b1;
        last_q <= frame_end;
      end else if (consume) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_window3x3.sv
// Bench for conv_window3x3: three instances (4x4, 8x8, 5x3) checked every cycle
// against an image-indexed window model, plus literal windows from hand calculation.
module tb_conv_window3x3;
  localparam int NB = 20;
  localparam int WV = 9 * NB;
  localparam int WS [3] = '{4, 8, 5};
  localparam int HS [3] = '{4, 8, 3};
  localparam int G [5][9] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                              '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                              '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                              '{5, 6, 7, 9, 10, 11, 13, 14, 15},
                              '{0, 1, 2, 5, 6, 7, 10, 11, 12}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    pv = '0;
  logic [2:0]    wr = '1;
  logic [NB-1:0] pin [3];
  wire  [2:0]    pr, wv, wl;
  wire  [WV-1:0] wout [3];

  int errors = 0, checks = 0, cyc = 0, acc10 = 0;

  // model state
  logic [NB-1:0] fimg [3][8][8];
  logic [WV-1:0] ew [3][16];
  bit            el [3][16];
  int            rdp [3], wrp [3], mrow [3], mcol [3];
  bit            mdrain [3];
  // log of consumed windows
  logic [WV-1:0] lw [3][128];
  bit            ll [3][128];
  int            lc [3][128];
  int            ln [3];

  conv_window3x3 #(.NBITS(NB), .IMG_W(4), .IMG_H(4)) u_4x4 (
    .clock(clk), .reset(rst), .pix_in(pin[0]), .pix_valid(pv[0]), .pix_ready(pr[0]),
    .win_out(wout[0]), .win_valid(wv[0]), .win_ready(wr[0]), .win_last(wl[0]));
  conv_window3x3 #(.NBITS(NB), .IMG_W(8), .IMG_H(8)) u_8x8 (
    .clock(clk), .reset(rst), .pix_in(pin[1]), .pix_valid(pv[1]), .pix_ready(pr[1]),
    .win_out(wout[1]), .win_valid(wv[1]), .win_ready(wr[1]), .win_last(wl[1]));
  conv_window3x3 #(.NBITS(NB), .IMG_W(5), .IMG_H(3)) u_5x3 (
    .clock(clk), .reset(rst), .pix_in(pin[2]), .pix_valid(pv[2]), .pix_ready(pr[2]),
    .win_out(wout[2]), .win_valid(wv[2]), .win_ready(wr[2]), .win_last(wl[2]));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial begin #2000000; $display("FAIL watchdog: simulation did not finish"); $fatal; end

  task automatic chk(input string name, input logic [WV+7:0] act, input logic [WV+7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WV-1:0] pk(input int k, input int off);
    pk = '0;
    for (int j = 0; j < 9; j++) pk[j*NB +: NB] = NB'(G[k][j] + off);
  endfunction

  // Compare process: outputs vs model, then advance the model for the coming edge.
  bit busy, epr, lastpix;
  logic [WV-1:0] w;
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk("reset_outputs", {5'd0, pr[i], wv[i], wl[i], wout[i]}, '0);
        rdp[i] = wrp[i]; mrow[i] = 0; mcol[i] = 0; mdrain[i] = 0;
      end else begin
        busy = (rdp[i] != wrp[i]);
        epr  = !mdrain[i] && !(busy && !wr[i]);
        chk("pix_ready", pr[i], epr);
        chk("win_valid", wv[i], busy);
        if (busy && wv[i]) begin
          chk("win_out", wout[i], ew[i][rdp[i]%16]);
          chk("win_last", wl[i], el[i][rdp[i]%16]);
        end
        if (wv[i] && wr[i]) begin
          if (ln[i] < 128) begin
            lw[i][ln[i]] = wout[i]; ll[i][ln[i]] = wl[i]; lc[i][ln[i]] = cyc; ln[i]++;
          end
          if (busy) begin
            if (el[i][rdp[i]%16]) mdrain[i] = 0;
            rdp[i]++;
          end
        end
        if (pv[i] && epr) begin
          fimg[i][mrow[i]][mcol[i]] = pin[i];
          lastpix = (mrow[i] == HS[i]-1) && (mcol[i] == WS[i]-1);
          if (mrow[i] >= 2 && mcol[i] >= 2) begin
            w = '0;
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++)
                w[(3*r+c)*NB +: NB] = fimg[i][mrow[i]-2+r][mcol[i]-2+c];
            ew[i][wrp[i]%16] = w; el[i][wrp[i]%16] = lastpix; wrp[i]++;
          end
          if (lastpix) begin
            mdrain[i] = 1; mrow[i] = 0; mcol[i] = 0;
          end else if (mcol[i] == WS[i]-1) begin
            mcol[i] = 0; mrow[i]++;
          end else mcol[i]++;
        end
      end
    end
  end

  // Streams n pixels into instance i; called and returning at posedge+1.
  task automatic send(input int i, input int n, input int base, input bit rnd_val, input bit rnd_gap);
    for (int k = 0; k < n; k++) begin
      bit a = 0;
      int budget = 0;
      pin[i] = rnd_val ? NB'($urandom) : NB'(base + k);
      while (!a) begin
        pv[i] = rnd_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk);
        a = pv[i] && pr[i];
        if (a && i == 0 && k == 10) acc10 = cyc;
        @(posedge clk); #1;
        if (++budget > 300) begin
          chk("send_timeout", 0, 1);
          pv[i] = 0;
          return;
        end
      end
    end
    pv[i] = 0;
  endtask

  // Holds win_ready low for 3 cycles once a (last, if requested) window is up.
  task automatic stall(input int i, input bit lastonly);
    logic [WV-1:0] held;
    int n = 0;
    while (!(wv[i] && (!lastonly || wl[i]))) begin
      @(posedge clk); #1;
      if (++n > 500) begin chk("stall_timeout", 0, 1); return; end
    end
    wr[i] = 0;
    held = wout[i];
    repeat (3) begin
      @(negedge clk);
      chk("stall_pix_ready", pr[i], 0);
      chk("stall_valid", wv[i], 1);
      chk("stall_hold", wout[i], held);
      @(posedge clk); #1;
    end
    wr[i] = 1;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_4x4(input int from, input int off, input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_win"}, lw[0][from+k], pk(k, off));
      chk({tag, "_last"}, ll[0][from+k], k == 3);
    end
  endtask

  initial begin
    int b, nl;
    bit done;
    for (int i = 0; i < 3; i++) pin[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // 4x4 stream, free-flowing
    b = ln[0];
    send(0, 16, 0, 0, 0); settle();
    chk("s1_count", ln[0] - b, 4);
    check_4x4(b, 0, "s1");
    chk("s1_latency", lc[0][b], acc10 + 1);

    // same stream with output stalled on the first window
    b = ln[0];
    fork send(0, 16, 0, 0, 0); stall(0, 0); join
    settle();
    chk("s2_count", ln[0] - b, 4);
    check_4x4(b, 0, "s2");

    // back-to-back frames, last window of frame 1 held in DRAIN
    b = ln[0];
    fork
      begin send(0, 16, 0, 0, 0); send(0, 16, 100, 0, 0); end
      stall(0, 1);
    join
    settle();
    chk("s4_count", ln[0] - b, 8);
    check_4x4(b, 0, "s4a");
    check_4x4(b + 4, 100, "s4b");

    // reset mid-frame, then a fresh frame
    send(0, 10, 0, 0, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    b = ln[0];
    send(0, 16, 0, 0, 0); settle();
    chk("s5_count", ln[0] - b, 4);
    check_4x4(b, 0, "s5");

    // 8x8 random data with random input gaps
    b = ln[1];
    send(1, 64, 0, 1, 1); settle();
    chk("s3_count", ln[1] - b, 36);
    nl = 0;
    for (int k = 0; k < 36; k++) nl += int'(ll[1][b+k]);
    chk("s3_last_count", nl, 1);
    chk("s3_last_pos", ll[1][b+35], 1);

    // 8x8 again with random backpressure as well
    b = ln[1];
    done = 0;
    fork
      begin send(1, 64, 0, 1, 1); done = 1; end
      begin
        while (!done) begin wr[1] = 1'($urandom % 2); @(posedge clk); #1; end
        wr[1] = 1;
      end
    join
    settle();
    chk("s3b_count", ln[1] - b, 36);

    // 5x3 continuous flow: three windows on consecutive cycles
    b = ln[2];
    send(2, 15, 0, 0, 0); settle();
    chk("s6_count", ln[2] - b, 3);
    chk("s6_first", lw[2][b], pk(4, 0));
    chk("s6_b2b_1", lc[2][b+1] - lc[2][b], 1);
    chk("s6_b2b_2", lc[2][b+2] - lc[2][b+1], 1);
    chk("s6_last", {ll[2][b], ll[2][b+1], ll[2][b+2]}, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_window3x3.md
Name: conv_window3x3

Overview:
- Upstream feeder for the 3x3 convolution datapath (param9 consumer).
- Accepts a raster-order pixel stream of one NBITS word per beat.
- Buffers two image lines and emits each fully-populated 3x3 window (no padding) as one flattened 9-word output beat.
- Valid/ready handshakes on both sides with full backpressure.

Parameters:
- NBITS, 20, pixel/word width (matches packConv::NBITS / regC).
- IMG_W, 8, image width in pixels; legal range >= 3.
- IMG_H, 8, image height in pixels; legal range >= 3.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_in  in  NBITS  input pixel, raster order (row 0 col 0 first).
- pix_valid  in  1  pix_in is valid.
- pix_ready  out  1  block accepts pix_in this cycle.
- win_out  out  9*NBITS  window; word k at bits [k*NBITS +: NBITS], k = 3*r + c, r/c = 0..2, r=0 is the oldest row, c=0 is the leftmost column.
- win_valid  out  1  win_out holds a valid window.
- win_ready  in  1  downstream accepts win_out.
- win_last  out  1  qualifies win_valid; marks the final window of a frame.

Behaviour:
- Accept: a pixel is accepted when pix_valid && pix_ready at a rising clock edge.
- Storage: two line buffers LB0 (previous row) and LB1 (row before that), IMG_W words each, indexed by col.
- Window register: 3x3 words.
- On accept at (row, col):
  - shift the window left one column;
  - new right column = {LB1[col], LB0[col], pix_in} for r = 0, 1, 2;
  - LB1[col] <= LB0[col];
  - LB0[col] <= pix_in.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accept; col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0.
- Window complete: the accept is window-completing iff row >= 2 && col >= 2 (values before the increment).
  - On the next edge, win_out/win_valid are loaded.
  - win_last = 1 iff row == IMG_H-1 && col == IMG_W-1.
- Latency: win_valid rises one cycle after the completing accept edge.
- Window count: exactly (IMG_W-2)*(IMG_H-2) windows per frame. Windows straddling a row wrap (col < 2) are never emitted.
- Output register: one entry.
  - win_valid holds, and win_out/win_last are stable, until win_valid && win_ready.
  - A handshake clears win_valid unless a new window loads on the same edge.
- pix_ready = (state != DRAIN) && (!win_valid || win_ready). A simultaneous window consume and completing accept is legal and yields back-to-back windows at one per cycle.
- FSM:
  - FILL: rows 0..1; no windows produced. Go to RUN when row becomes 2.
  - RUN: producing windows. After accepting the last pixel of the frame, go to DRAIN.
  - DRAIN: pix_ready = 0. Wait for the win_last beat to be consumed, then go to FILL (next frame).
- Reset (any time, including mid-frame):
  - state = FILL; row = col = 0;
  - win_valid = 0, win_last = 0, win_out = 0;
  - pix_ready is 1 after release.
  - Line buffer and window contents need not be reset; they are rewritten before any use.
  - A partial frame is discarded, and the next pixel is treated as row 0 col 0.
- Idle input: with pix_valid = 0, no state changes and no new windows.
- Arithmetic: pure data movement, no width change; each pixel is passed bit-exact.

Test Plan:
- IMG_W=IMG_H=4, pixels 0..15 streamed with pix_valid=1 and win_ready=1 -> exactly 4 windows, in order:
  - {0,1,2,4,5,6,8,9,10}
  - {1,2,3,5,6,7,9,10,11}
  - {4,5,6,8,9,10,12,13,14}
  - {5,6,7,9,10,11,13,14,15}, win_last=1 on this window only.
  - First win_valid appears one cycle after pixel 10 is accepted.
- Same stream, win_ready held 0 for 3 cycles while win_valid=1 -> win_out stable, pix_ready=0, no pixel lost; after release the full window sequence is identical to scenario 1.
- pix_valid toggled randomly, 8x8 frame, win_ready=1 -> 36 windows; each matches a golden model; win_last is set only on the 36th.
- Two back-to-back 4x4 frames (second frame values 100..115) -> during DRAIN pix_ready stays 0 until the last window is consumed; the second frame's first window is {100,101,102,104,105,106,108,109,110} with no leakage from frame 1.
- Reset asserted after pixel 9 of a frame, then a fresh 4x4 frame 0..15 -> no window is emitted from the partial frame; output equals scenario 1; all outputs read 0 during reset.
- Continuous flow: win_ready=1, pix_valid=1, IMG_W=5, IMG_H=3 -> windows at consecutive cycles for cols 2..4 of row 2 (3 windows, one per clock).
